// File: rtl/ffe_demux_1x2_deint.sv
// Serial-to-pair deinterleaver for the 2-parallel FFE: the first accepted sample goes to the even
// lane and the second to the odd lane. Each pair is presented downstream with a valid/ready handshake.
module ffe_demux_1x2_deint #(
    parameter int unsigned data_width = 12,
    parameter int unsigned cnt_width  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sync_clear,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_even,
    output logic [data_width-1:0] out_odd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  half_pair,
    output logic [cnt_width-1:0]  pair_cnt
);

    typedef enum logic [1:0] {
        StEven = 2'b00,
        StOdd  = 2'b01,
        StFull = 2'b10
    } state_e;

    state_e                state;
    logic [data_width-1:0] even_reg;
    logic                  in_xfer;
    logic                  out_xfer;

    // In StFull a slot frees up only when the held pair leaves in this same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (RST && !sync_clear) begin
            case (state)
                StFull:  in_ready = out_ready;
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign half_pair = (state == StOdd);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= StEven;
            even_reg  <= '0;
            out_even  <= '0;
            out_odd   <= '0;
            out_valid <= 1'b0;
            pair_cnt  <= '0;
        end else if (sync_clear) begin
            // Realign: any partial or pending pair is dropped uncounted; the last pair stays visible.
            state     <= StEven;
            even_reg  <= '0;
            out_valid <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            if (out_xfer) begin
                pair_cnt <= pair_cnt + cnt_width'(1);
            end
            case (state)
                StEven: begin
                    if (in_xfer) begin
                        even_reg <= in_data;
                        state    <= StOdd;
                    end
                end
                StOdd: begin
                    if (in_xfer) begin
                        out_even  <= even_reg;
                        out_odd   <= in_data;
                        out_valid <= 1'b1;
                        state     <= StFull;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_xfer) begin
                            even_reg <= in_data;
                            state    <= StOdd;
                        end else begin
                            state <= StEven;
                        end
                    end
                end
                default: begin
                    state     <= StEven;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
